// File: rtl/pc_fetch_unit.sv
// PC register, next-PC selection and instruction-memory request/ready sequencing.
// Optional `PC_TRAP_MISALIGN_EN`: halt with a sticky flag on misaligned branch targets instead of aligning them.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] adder2_out,
  input  logic        Branch,
  input  logic        Zero,
  input  logic        Jump,
  input  logic [25:0] JumpAddr,
  input  logic        halt_req,
  input  logic        imem_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic        pc_valid,
  output logic        halted,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    FETCH      = 2'd1,
    EXEC       = 2'd2,
    HALT       = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        misalign_q, misalign_d;

  logic [31:0] jump_target;
  logic [31:0] sel_target;
  logic [31:0] next_pc;
  logic        trap;

  // Target selection: jump beats a taken branch, which beats the sequential PC.
  always_comb begin
    pc_plus4    = pc_q + 32'd4;
    jump_target = {pc_plus4[31:28], JumpAddr, 2'b00};
    if (Jump) begin
      sel_target = jump_target;
    end else if (Branch && Zero) begin
      sel_target = adder2_out;
    end else begin
      sel_target = pc_plus4;
    end
`ifdef PC_TRAP_MISALIGN_EN
    next_pc = sel_target;
    trap    = !Jump && Branch && Zero && (sel_target[1:0] != 2'b00);
`else
    next_pc = sel_target & ~32'h3;
    trap    = 1'b0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = misalign_q;
    case (state_q)
      RESET_HOLD: begin
        pc_d    = RESET_PC;
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) state_d = EXEC;
      end
      EXEC: begin
        // A trap leaves the PC on the faulting instruction so it can be inspected.
        if (trap) begin
          misalign_d = 1'b1;
          state_d    = HALT;
        end else begin
          pc_d    = next_pc;
          state_d = halt_req ? HALT : FETCH;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RESET_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESET_HOLD;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_out       = pc_q;
  assign imem_req     = (state_q == FETCH);
  assign pc_valid     = (state_q == EXEC);
  assign halted       = (state_q == HALT);
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: vector table for the main flow, hand sequences for halt, reset and misalign.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adder2_out;
  logic        Branch, Zero, Jump, halt_req, imem_ready;
  logic [25:0] JumpAddr;
  logic [31:0] pc_out, pc_plus4, pc_out2, pc_plus4_2;
  logic        imem_req, pc_valid, halted, misalign_err;
  logic        imem_req2, pc_valid2, halted2, misalign_err2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .adder2_out(adder2_out), .Branch(Branch), .Zero(Zero),
    .Jump(Jump), .JumpAddr(JumpAddr), .halt_req(halt_req), .imem_ready(imem_ready),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .imem_req(imem_req), .pc_valid(pc_valid),
    .halted(halted), .misalign_err(misalign_err)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .reset(reset), .adder2_out(adder2_out), .Branch(Branch), .Zero(Zero),
    .Jump(Jump), .JumpAddr(JumpAddr), .halt_req(halt_req), .imem_ready(imem_ready),
    .pc_out(pc_out2), .pc_plus4(pc_plus4_2), .imem_req(imem_req2), .pc_valid(pc_valid2),
    .halted(halted2), .misalign_err(misalign_err2)
  );

  typedef struct {
    logic        rdy, br, zr, jmp, hlt;
    logic [31:0] a2;
    logic [25:0] ja;
    logic [31:0] pc;
    logic        req, vld, hlted;
  } vec_t;

  vec_t tbl [27];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [31:0] pc, input logic req,
                         input logic vld, input logic h, input logic mis);
    chk({nm, ".pc_out"}, pc_out, pc);
    chk({nm, ".pc_plus4"}, pc_plus4, pc + 32'd4);
    chk({nm, ".imem_req"}, {31'd0, imem_req}, {31'd0, req});
    chk({nm, ".pc_valid"}, {31'd0, pc_valid}, {31'd0, vld});
    chk({nm, ".halted"}, {31'd0, halted}, {31'd0, h});
    chk({nm, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, mis});
  endtask

  task automatic clear_ctrl();
    Branch = 0; Zero = 0; Jump = 0; JumpAddr = '0; adder2_out = '0; halt_req = 0;
  endtask

  initial begin
    //            rdy br zr jmp hlt a2            ja        pc            req vld h
    tbl[0]  = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         1, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h0,         0, 1, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 32'h0,         26'h0,   32'h4,         1, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h4,         0, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 32'h0,         26'h0,   32'h8,         1, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h8,         0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 32'h0,         26'h0,   32'hC,         1, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'hC,         0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 32'h0,         26'h0,   32'h10,        1, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h10,        0, 1, 0};
    tbl[10] = '{0, 1, 1, 0, 0, 32'h40,        26'h0,   32'h40,        1, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h40,        0, 1, 0};
    tbl[12] = '{0, 1, 1, 1, 0, 32'h80,        26'h100, 32'h400,       1, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h400,       0, 1, 0};
    tbl[14] = '{0, 1, 1, 0, 0, 32'h10,        26'h0,   32'h10,        1, 0, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h10,        0, 1, 0};
    tbl[16] = '{0, 1, 0, 0, 0, 32'h40,        26'h0,   32'h14,        1, 0, 0};
    tbl[17] = '{0, 1, 1, 1, 1, 32'h80,        26'h3,   32'h14,        1, 0, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 32'h0,         26'h0,   32'h14,        1, 0, 0};
    tbl[19] = '{0, 0, 0, 0, 0, 32'h0,         26'h0,   32'h14,        1, 0, 0};
    tbl[20] = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h14,        0, 1, 0};
    tbl[21] = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h18,        1, 0, 0};
    tbl[22] = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h18,        0, 1, 0};
    tbl[23] = '{0, 1, 1, 0, 0, 32'h3FFF_FFFC, 26'h0,   32'h3FFF_FFFC, 1, 0, 0};
    tbl[24] = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h3FFF_FFFC, 0, 1, 0};
    tbl[25] = '{0, 0, 0, 1, 0, 32'h0,         26'h10,  32'h4000_0040, 1, 0, 0};
    tbl[26] = '{1, 0, 0, 0, 0, 32'h0,         26'h0,   32'h4000_0040, 0, 1, 0};

    clear_ctrl();
    imem_ready = 0;
    reset = 1;
    step();
    step();
    chk_all("reset", 32'h0, 0, 0, 0, 0);
    chk("wrap_reset.pc_out", pc_out2, 32'hFFFF_FFFC);
    chk("wrap_reset.pc_plus4", pc_plus4_2, 32'h0);
    reset = 0;

    for (int i = 0; i < 27; i++) begin
      imem_ready = tbl[i].rdy; Branch = tbl[i].br; Zero = tbl[i].zr; Jump = tbl[i].jmp;
      halt_req = tbl[i].hlt; adder2_out = tbl[i].a2; JumpAddr = tbl[i].ja;
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].pc, tbl[i].req, tbl[i].vld, tbl[i].hlted, 1'b0);
    end

    // Halt after the instruction at 0x8, then verify the PC stays frozen.
    clear_ctrl();
    reset = 1; step(); reset = 0;
    imem_ready = 1;
    for (int i = 0; i < 3; i++) step();
    chk("wrap_step.pc_out", pc_out2, 32'h0);
    for (int i = 0; i < 3; i++) step();
    chk_all("exec8", 32'h8, 0, 1, 0, 0);
    halt_req = 1;
    step();
    chk_all("halt_enter", 32'hC, 0, 0, 1, 0);
    halt_req = 0; Jump = 1; JumpAddr = 26'h123;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all($sformatf("halt_hold%0d", i), 32'hC, 0, 0, 1, 0);
    end
    clear_ctrl();
    reset = 1; step();
    chk_all("reset_from_halt", 32'h0, 0, 0, 0, 0);
    reset = 0;

    // Reset in the middle of a FETCH wait.
    imem_ready = 0;
    step();
    chk_all("wait0", 32'h0, 1, 0, 0, 0);
    step();
    chk_all("wait1", 32'h0, 1, 0, 0, 0);
    reset = 1; step();
    chk_all("reset_from_wait", 32'h0, 0, 0, 0, 0);
    reset = 0;

    // Misaligned taken branch from the instruction at 0x0.
    imem_ready = 1;
    step(); step();
    chk_all("exec0", 32'h0, 0, 1, 0, 0);
    Branch = 1; Zero = 1; adder2_out = 32'h42; imem_ready = 0;
    step();
`ifdef PC_TRAP_MISALIGN_EN
    chk_all("misalign", 32'h0, 0, 0, 1, 1);
    clear_ctrl(); imem_ready = 1;
    step(); step();
    chk_all("misalign_sticky", 32'h0, 0, 0, 1, 1);
`else
    chk_all("misalign", 32'h40, 1, 0, 0, 0);
    clear_ctrl();
    step(); step();
    chk_all("misalign_after", 32'h40, 1, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
